// File: rtl/writeback_unit_pkg.sv
// Shared widths and helpers for the writeback unit.
// The machine-wide width macros are defined here, once, for every file that follows.
`ifndef LEN_REG_ADDR
`define LEN_REG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 64
`endif

package writeback_unit_pkg;
  localparam int LREG     = `LEN_REG_ADDR;
  localparam int LWORD    = `LEN_WORD;
  localparam int NUM_REGS = `NUM_REGS;

  // Round-robin successor of idx among n slots.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// Result-source bus: NSRC producers offer {ard, drd}; src_ready is a one-hot grant.
// A result transfers on the cycle src_valid[i] & src_ready[i]; ready never depends on data.
interface writeback_unit_if #(parameter int NSRC = 3);
  import writeback_unit_pkg::*;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC*LREG-1:0]  src_ard;
  logic [NSRC*LWORD-1:0] src_drd;
  logic [NSRC-1:0]       src_ready;

  modport master (output src_valid, output src_ard, output src_drd, input src_ready);
  modport slave  (input src_valid, input src_ard, input src_drd, output src_ready);
endinterface

// File: rtl/writeback_unit_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping;
// the pointer moves past the winner only when the grant is used.
module rr_arbiter
  import writeback_unit_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;

  always_comb begin
    int idx;
    o_gnt   = '0;
    w_gidx  = r_ptr;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!w_found && i_req[idx]) begin
        w_found    = 1'b1;
        o_gnt[idx] = 1'b1;
        w_gidx     = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)      r_ptr <= '0;
    else if (i_adv) r_ptr <= PW'(next_idx(int'(w_gidx), N));
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: arbitrates result sources onto the single write port and keeps
// a per-register outstanding-write count that drives decode hazard and stall flags.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int NREG  = NUM_REGS,
  parameter int CNT_W = 2,
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  writeback_unit_if.slave       i_src,
  output logic [LREG-1:0]       o_ard,
  output logic [LWORD-1:0]      o_drd,
  input  logic                  i_iss_valid,
  input  logic [LREG-1:0]       i_iss_ard,
  output logic                  o_iss_stall,
  input  logic [LREG-1:0]       i_ars1,
  input  logic [LREG-1:0]       i_ars2,
  output logic                  o_hz_rs1,
  output logic                  o_hz_rs2,
  output logic [PW-1:0]         o_dbg_ptr,
  output logic [NREG*CNT_W-1:0] o_dbg_cnt
);
  logic [NSRC-1:0]  w_gnt;
  logic [NSRC-1:0]  w_ready;
  logic             w_xfer;
  logic [LREG-1:0]  w_sel_ard;
  logic [LWORD-1:0] w_sel_drd;
  logic [LREG-1:0]  r_ard;
  logic [LWORD-1:0] r_drd;
  logic [CNT_W-1:0] w_cnt [NREG];

  rr_arbiter #(.N(NSRC)) u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .i_req (i_src.src_valid),
    .i_adv (w_xfer),
    .o_gnt (w_gnt),
    .o_ptr (o_dbg_ptr)
  );

  // Grants are masked during reset so nothing is consumed while the unit is held.
  assign w_ready         = w_gnt & {NSRC{rstn}};
  assign i_src.src_ready = w_ready;
  assign w_xfer          = |(w_ready & i_src.src_valid);

  always_comb begin
    w_sel_ard = '0;
    w_sel_drd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_gnt[i]) begin
        w_sel_ard = i_src.src_ard[i*LREG +: LREG];
        w_sel_drd = i_src.src_drd[i*LWORD +: LWORD];
      end
    end
  end

  // ard is a one-cycle pulse; drd keeps its last value when nothing is written.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ard <= '0;
      r_drd <= '0;
    end else if (w_xfer) begin
      r_ard <= w_sel_ard;
      r_drd <= w_sel_drd;
    end else begin
      r_ard <= '0;
    end
  end

  assign o_ard = r_ard;
  assign o_drd = r_drd;

  assign o_iss_stall = i_iss_valid && (i_iss_ard != '0) && (w_cnt[i_iss_ard] == '1);

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign w_cnt[r] = '0;
    end else begin : g_reg
      logic [CNT_W-1:0] r_c;
      logic             w_inc;
      logic             w_dec;
      assign w_inc = i_iss_valid && !o_iss_stall && (i_iss_ard == LREG'(r));
      // Decrement on the edge the regfile commits; a zero counter never underflows.
      assign w_dec = (r_ard == LREG'(r));
      always_ff @(posedge clk) begin
        if (!rstn)                              r_c <= '0;
        else if (w_inc && !w_dec)               r_c <= r_c + CNT_W'(1);
        else if (w_dec && !w_inc && r_c != '0)  r_c <= r_c - CNT_W'(1);
      end
      assign w_cnt[r] = r_c;
    end
    assign o_dbg_cnt[r*CNT_W +: CNT_W] = w_cnt[r];
  end

  assign o_hz_rs1 = (i_ars1 != '0) && (w_cnt[i_ars1] != '0);
  assign o_hz_rs2 = (i_ars2 != '0) && (w_cnt[i_ars2] != '0);
endmodule
